// File: rtl/image_loader.sv
// Serial-to-parallel binary image loader.
// Streams HEIGHT x LENGTH pixels in raster order into a packed frame and counts the ones.
module image_loader #(
   parameter int unsigned HEIGHT = 28,
   parameter int unsigned LENGTH = 28,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           pix_valid,
   output logic                           pix_ready,
   input  logic                           pix_data,
   input  logic                           pix_last,
   output logic                           img_valid,
   input  logic                           img_ready,
   output logic [HEIGHT-1:0][LENGTH-1:0]  image,
   output logic [CNT_W-1:0]               ones_count,
   output logic                           frame_err
);

   localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int unsigned CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(LENGTH - 1);

   typedef enum logic {LOAD, DONE} state_t;

   state_t          state;
   logic [RW-1:0]   row;
   logic [CW-1:0]   col;
   logic            accept;
   logic            final_pix;

   assign pix_ready = (state == LOAD);
   assign img_valid = (state == DONE);

   always_comb begin
      accept    = pix_valid && (state == LOAD);
      final_pix = (row == ROW_LAST) && (col == COL_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LOAD;
         row        <= '0;
         col        <= '0;
         image      <= '0;
         ones_count <= '0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         case (state)
            LOAD: begin
               if (accept) begin
                  image[row][col] <= pix_data;
                  if (final_pix) begin
                     // A missing pix_last on the final pixel still completes the frame.
                     ones_count <= ones_count + CNT_W'(pix_data);
                     frame_err  <= ~pix_last;
                     state      <= DONE;
                  end else if (pix_last) begin
                     // Early last: restart the frame but leave the image contents alone.
                     frame_err  <= 1'b1;
                     row        <= '0;
                     col        <= '0;
                     ones_count <= '0;
                  end else begin
                     ones_count <= ones_count + CNT_W'(pix_data);
                     if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 1'b1;
                     end else begin
                        col <= col + 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if (img_ready) begin
                  state      <= LOAD;
                  row        <= '0;
                  col        <= '0;
                  ones_count <= '0;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: stimulus pushes expected frames, a monitor pops them
// whenever a frame is handed off.
module tb_image_loader;

   localparam int unsigned H = 28;
   localparam int unsigned L = 28;
   localparam int unsigned CW = 32;

   typedef logic [H-1:0][L-1:0] img_t;
   typedef struct {
      img_t        img;
      int unsigned cnt;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            pix_valid;
   logic            pix_ready;
   logic            pix_data;
   logic            pix_last;
   logic            img_valid;
   logic            img_ready;
   img_t            image;
   logic [CW-1:0]   ones_count;
   logic            frame_err;

   int   tests = 0;
   int   fails = 0;
   int   err_seen = 0;
   exp_t q[$];

   image_loader #(.HEIGHT(H), .LENGTH(L), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_data   (pix_data),
      .pix_last   (pix_last),
      .img_valid  (img_valid),
      .img_ready  (img_ready),
      .image      (image),
      .ones_count (ones_count),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_img(input string name, input img_t act, input img_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic pat(input int kind, input int i, input int j);
      case (kind)
         0:       return 1'b1;
         1:       return ((i + j) % 2) == 1;
         2:       return i == j;
         3:       return 1'b0;
         4:       return j < i;
         default: return (j % 3) == 0;
      endcase
   endfunction

   function automatic img_t make_img(input int kind);
      img_t m;
      for (int i = 0; i < int'(H); i++)
         for (int j = 0; j < int'(L); j++)
            m[i][j] = pat(kind, i, j);
      return m;
   endfunction

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic send_pixel(input logic d, input logic last);
      int n;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = last;
      n = 0;
      while (!pix_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!pix_ready) begin
         tests++;
         fails++;
         $display("FAIL pix_ready_timeout: got 0 expected 1");
      end
      @(negedge clk);
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic send_frame(input int kind, input int unsigned cnt, input bit with_last,
                             input bit gaps);
      exp_t e;
      e.img = make_img(kind);
      e.cnt = cnt;
      q.push_back(e);
      for (int i = 0; i < int'(H); i++)
         for (int j = 0; j < int'(L); j++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_pixel(e.img[i][j], with_last && (i == int'(H) - 1) && (j == int'(L) - 1));
         end
      chk("img_valid_after_last", 64'(img_valid), 64'd1);
      chk("frame_err_on_final", 64'(frame_err), 64'(!with_last));
   endtask

   // Monitor: samples 2 time units after the stimulus-driving negedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (frame_err === 1'b1) err_seen++;
         if (img_valid === 1'b1 && img_ready === 1'b1) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_frame: got 1 frame expected 0");
            end else begin
               e = q.pop_front();
               chk_img("frame_image", image, e.img);
               chk("frame_ones_count", 64'(ones_count), 64'(e.cnt));
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      img_t exp_img;
      bit   bad;
      int   n;
      rst = 1'b1; pix_valid = 1'b0; pix_data = 1'b0; pix_last = 1'b0; img_ready = 1'b1;
      repeat (3) @(negedge clk);
      // Pixels offered during reset are dropped.
      pix_valid = 1'b1; pix_data = 1'b1;
      @(negedge clk);
      rst = 1'b0; pix_valid = 1'b0; pix_data = 1'b0;
      chk("reset_pix_ready", 64'(pix_ready), 64'd1);
      chk("reset_img_valid", 64'(img_valid), 64'd0);
      chk("reset_ones_count", 64'(ones_count), 64'd0);
      chk("reset_frame_err", 64'(frame_err), 64'd0);
      chk_img("reset_image", image, '0);

      // 1: all ones
      send_frame(0, 784, 1'b1, 1'b0);
      // 2: checkerboard with random gaps
      send_frame(1, 392, 1'b1, 1'b1);

      // 3: consumer stall in DONE while the source keeps offering data
      @(negedge clk);
      img_ready = 1'b0;
      send_frame(2, 28, 1'b1, 1'b0);
      exp_img = make_img(2);
      pix_valid = 1'b1; pix_data = 1'b1;
      bad = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (pix_ready !== 1'b0 || img_valid !== 1'b1 || image !== exp_img ||
             ones_count !== 32'd28)
            bad = 1'b1;
      end
      chk("stall_hold_stable", 64'(bad), 64'd0);
      pix_valid = 1'b0; pix_data = 1'b0;
      img_ready = 1'b1;
      @(negedge clk);
      chk("handoff_pix_ready", 64'(pix_ready), 64'd1);
      chk("handoff_img_valid", 64'(img_valid), 64'd0);
      chk("handoff_ones_cleared", 64'(ones_count), 64'd0);

      // 4: early pix_last on pixel #100
      for (int k = 1; k < 100; k++) send_pixel(1'b1, 1'b0);
      send_pixel(1'b1, 1'b1);
      chk("early_last_err", 64'(frame_err), 64'd1);
      chk("early_last_count_clr", 64'(ones_count), 64'd0);
      chk("early_last_state", 64'(pix_ready), 64'd1);
      @(negedge clk);
      chk("early_last_pulse_width", 64'(frame_err), 64'd0);
      send_frame(3, 0, 1'b1, 1'b0);

      // 5: pix_last never asserted
      send_frame(4, 378, 1'b0, 1'b0);

      // 6: reset at pixel #300
      for (int k = 1; k < 300; k++) send_pixel(1'b1, 1'b0);
      rst = 1'b1; pix_valid = 1'b1; pix_data = 1'b1;
      @(negedge clk);
      rst = 1'b0; pix_valid = 1'b0; pix_data = 1'b0;
      chk("midreset_img_valid", 64'(img_valid), 64'd0);
      chk("midreset_ones_count", 64'(ones_count), 64'd0);
      chk("midreset_frame_err", 64'(frame_err), 64'd0);
      chk_img("midreset_image", image, '0);
      send_frame(5, 280, 1'b1, 1'b0);

      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      chk("frame_err_pulses", 64'(err_seen), 64'd2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
